// File: rtl/multi_sprite_compositor.sv
// N-sprite bouncing overlay for the pixel path: two-stage pipeline returning the colour and index
// of the highest-priority opaque sprite, plus a per-frame sticky overlap flag.
module multi_sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SCALE_LOG2  = 2,
    parameter int SCREEN_W    = 1280,
    parameter int SCREEN_H    = 720,
    parameter int INIT_DX     = 256,
    parameter int INIT_DY     = 96
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_de,
    input  logic        i_v_sync,
    input  logic        i_move_en,
    output logic [7:0]  o_red,
    output logic [7:0]  o_green,
    output logic [7:0]  o_blue,
    output logic        o_sprite_hit,
    output logic [2:0]  o_sprite_id,
    output logic        o_de,
    output logic        o_collision
);

    localparam int          SPAN   = 16 << SCALE_LOG2;
    localparam logic [15:0] SPAN_W = 16'(SPAN);
    localparam logic [15:0] X_MAX  = 16'(SCREEN_W - SPAN);
    localparam logic [15:0] Y_MAX  = 16'(SCREEN_H - SPAN);

    function automatic logic [1:0] bitmap_px(input logic [3:0] row, input logic [3:0] col);
        logic [1:0] px;
        px = 2'd0;
        if (row == 4'd1 && col == 4'd6) px = 2'd1;
        if (row == 4'd9 && col >= 4'd1 && col <= 4'd14) px = 2'd1;
        if (row == 4'd3 && col == 4'd5) px = 2'd2;
        return px;
    endfunction

    // Frame-start detector; armed_q suppresses a pulse from a v_sync already high at reset release.
    logic vs_prev_q, vs_prev_d, armed_q, armed_d, fs;

    logic [15:0]            x_q [NUM_SPRITES];
    logic [15:0]            x_d [NUM_SPRITES];
    logic [15:0]            y_q [NUM_SPRITES];
    logic [15:0]            y_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] xdir_q, xdir_d, ydir_q, ydir_d, flip_q, flip_d;

    logic [15:0]            off_x [NUM_SPRITES];
    logic [15:0]            off_y [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] hit_s1_q, hit_s1_d;
    logic [3:0]             col_s1_q [NUM_SPRITES];
    logic [3:0]             col_s1_d [NUM_SPRITES];
    logic [3:0]             row_s1_q [NUM_SPRITES];
    logic [3:0]             row_s1_d [NUM_SPRITES];
    logic                   de_s1_q, de_s1_d;

    logic [1:0] tex_idx [NUM_SPRITES];
    logic       win_any;
    logic [2:0] win_id;
    logic [1:0] win_idx;
    logic [3:0] n_opaque;

    logic [7:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic       hit_q, hit_d, de_s2_q, de_s2_d, collision_q, collision_d;
    logic [2:0] id_q, id_d;

    always_comb begin
        vs_prev_d = i_v_sync;
        armed_d   = 1'b1;
        fs        = armed_q && i_v_sync && !vs_prev_q;
    end

    // Bounce: at an edge the sprite steps back inward in the same frame it turns around.
    always_comb begin
        xdir_d = xdir_q;
        ydir_d = ydir_q;
        flip_d = flip_q;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            x_d[i] = x_q[i];
            y_d[i] = y_q[i];
            if (fs && i_move_en) begin
                if (xdir_q[i]) begin
                    if (x_q[i] >= X_MAX) begin
                        x_d[i]    = X_MAX - 16'd1;
                        xdir_d[i] = 1'b0;
                        flip_d[i] = 1'b1;
                    end else begin
                        x_d[i] = x_q[i] + 16'd1;
                    end
                end else begin
                    if (x_q[i] == 16'd0) begin
                        x_d[i]    = 16'd1;
                        xdir_d[i] = 1'b1;
                        flip_d[i] = 1'b0;
                    end else begin
                        x_d[i] = x_q[i] - 16'd1;
                    end
                end
                if (ydir_q[i]) begin
                    if (y_q[i] >= Y_MAX) begin
                        y_d[i]    = Y_MAX - 16'd1;
                        ydir_d[i] = 1'b0;
                    end else begin
                        y_d[i] = y_q[i] + 16'd1;
                    end
                end else begin
                    if (y_q[i] == 16'd0) begin
                        y_d[i]    = 16'd1;
                        ydir_d[i] = 1'b1;
                    end else begin
                        y_d[i] = y_q[i] - 16'd1;
                    end
                end
            end
        end
    end

    // Stage 1: offsets wrap for pixels left/above the sprite, but the hit term masks them.
    always_comb begin
        de_s1_d  = i_de;
        hit_s1_d = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            off_x[i]    = i_x - x_q[i];
            off_y[i]    = i_y - y_q[i];
            hit_s1_d[i] = i_de && (i_x >= x_q[i]) && (off_x[i] < SPAN_W)
                               && (i_y >= y_q[i]) && (off_y[i] < SPAN_W);
            col_s1_d[i] = flip_q[i] ? (4'd15 - 4'(off_x[i] >> SCALE_LOG2))
                                    : 4'(off_x[i] >> SCALE_LOG2);
            row_s1_d[i] = 4'(off_y[i] >> SCALE_LOG2);
        end
    end

    // Stage 2: descending scan so the lowest opaque index is the last to claim the pixel.
    always_comb begin
        win_any  = 1'b0;
        win_id   = 3'd0;
        win_idx  = 2'd0;
        n_opaque = 4'd0;
        de_s2_d  = de_s1_q;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            tex_idx[i] = bitmap_px(row_s1_q[i], col_s1_q[i]);
            if (hit_s1_q[i] && tex_idx[i] != 2'd0) begin
                win_any  = 1'b1;
                win_id   = 3'(i);
                win_idx  = tex_idx[i];
                n_opaque = n_opaque + 4'd1;
            end
        end
        red_d   = 8'h00;
        green_d = 8'h00;
        blue_d  = 8'h00;
        case (win_idx)
            2'd1:    red_d = 8'hFF;
            2'd2:    begin red_d = 8'hFF; green_d = 8'hFF; blue_d = 8'hFF; end
            2'd3:    begin red_d = 8'h21; green_d = 8'h21; blue_d = 8'hFF; end
            default: ;
        endcase
        hit_d       = win_any;
        id_d        = win_id;
        collision_d = fs ? 1'b0 : collision_q;
        if (n_opaque >= 4'd2) collision_d = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vs_prev_q   <= 1'b0;
            armed_q     <= 1'b0;
            xdir_q      <= '1;
            ydir_q      <= '1;
            flip_q      <= '0;
            hit_s1_q    <= '0;
            de_s1_q     <= 1'b0;
            red_q       <= 8'h00;
            green_q     <= 8'h00;
            blue_q      <= 8'h00;
            hit_q       <= 1'b0;
            id_q        <= 3'd0;
            de_s2_q     <= 1'b0;
            collision_q <= 1'b0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]      <= 16'(i * INIT_DX);
                y_q[i]      <= 16'(i * INIT_DY);
                col_s1_q[i] <= 4'd0;
                row_s1_q[i] <= 4'd0;
            end
        end else begin
            vs_prev_q   <= vs_prev_d;
            armed_q     <= armed_d;
            xdir_q      <= xdir_d;
            ydir_q      <= ydir_d;
            flip_q      <= flip_d;
            hit_s1_q    <= hit_s1_d;
            de_s1_q     <= de_s1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hit_q       <= hit_d;
            id_q        <= id_d;
            de_s2_q     <= de_s2_d;
            collision_q <= collision_d;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                x_q[i]      <= x_d[i];
                y_q[i]      <= y_d[i];
                col_s1_q[i] <= col_s1_d[i];
                row_s1_q[i] <= row_s1_d[i];
            end
        end
    end

    assign o_red        = red_q;
    assign o_green      = green_q;
    assign o_blue       = blue_q;
    assign o_sprite_hit = hit_q;
    assign o_sprite_id  = id_q;
    assign o_de         = de_s2_q;
    assign o_collision  = collision_q;

endmodule

// File: tb/tb_multi_sprite_compositor.sv
// Bench for multi_sprite_compositor: three parameterisations driven in lockstep and compared
// against a triangle-wave position model and a direct per-pixel compositing model.
module tb_multi_sprite_compositor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] i_x, i_y;
    logic        i_de, i_v_sync, i_move_en;
    logic [7:0]  red [3];
    logic [7:0]  green [3];
    logic [7:0]  blue [3];
    logic        hit [3];
    logic [2:0]  sid [3];
    logic        ode [3];
    logic        coll [3];

    multi_sprite_compositor dut0 (
        .i_clk(clk), .i_rst(rst), .i_x(i_x), .i_y(i_y), .i_de(i_de), .i_v_sync(i_v_sync),
        .i_move_en(i_move_en), .o_red(red[0]), .o_green(green[0]), .o_blue(blue[0]),
        .o_sprite_hit(hit[0]), .o_sprite_id(sid[0]), .o_de(ode[0]), .o_collision(coll[0]));

    multi_sprite_compositor #(.NUM_SPRITES(2), .INIT_DX(32), .INIT_DY(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_x(i_x), .i_y(i_y), .i_de(i_de), .i_v_sync(i_v_sync),
        .i_move_en(i_move_en), .o_red(red[1]), .o_green(green[1]), .o_blue(blue[1]),
        .o_sprite_hit(hit[1]), .o_sprite_id(sid[1]), .o_de(ode[1]), .o_collision(coll[1]));

    multi_sprite_compositor #(.NUM_SPRITES(1), .SCREEN_W(80)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_x(i_x), .i_y(i_y), .i_de(i_de), .i_v_sync(i_v_sync),
        .i_move_en(i_move_en), .o_red(red[2]), .o_green(green[2]), .o_blue(blue[2]),
        .o_sprite_hit(hit[2]), .o_sprite_id(sid[2]), .o_de(ode[2]), .o_collision(coll[2]));

    typedef struct packed {
        logic [7:0] r, g, b;
        logic       hit;
        logic [2:0] id;
        logic       de;
        logic       multi;
    } exp_t;

    int cfg_n  [3] = '{4, 2, 1};
    int cfg_dx [3] = '{256, 32, 256};
    int cfg_dy [3] = '{96, 0, 96};
    int cfg_xm [3] = '{1216, 1216, 16};
    localparam int YM = 656;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   nmov;
    bit   vs_prev, armed;
    bit   mcoll [3];
    bit   prev_multi [3];
    exp_t qe [$];

    // Position after t unit steps along a 0..m bounce path (period 2m).
    function automatic int tri_pos(int t, int m);
        int q;
        if (t == 0) return 0;
        q = ((t - 1) % (2 * m)) + 1;
        return (q <= m) ? q : 2 * m - q;
    endfunction

    function automatic bit tri_flip(int t, int m);
        int q;
        if (t == 0) return 1'b0;
        q = ((t - 1) % (2 * m)) + 1;
        return q > m;
    endfunction

    function automatic int bmp(int row, int col);
        if (row == 1 && col == 6) return 1;
        if (row == 9 && col >= 1 && col <= 14) return 1;
        if (row == 3 && col == 5) return 2;
        return 0;
    endfunction

    function automatic exp_t model_px(int k, int px, int py, bit de);
        exp_t e;
        int cnt, sx, sy, col, row, v;
        bit fl;
        e   = '0;
        cnt = 0;
        for (int i = 0; i < cfg_n[k]; i++) begin
            sx = tri_pos(i * cfg_dx[k] + nmov, cfg_xm[k]);
            fl = tri_flip(i * cfg_dx[k] + nmov, cfg_xm[k]);
            sy = tri_pos(i * cfg_dy[k] + nmov, YM);
            if (de && px >= sx && px < sx + 64 && py >= sy && py < sy + 64) begin
                col = (px - sx) / 4;
                row = (py - sy) / 4;
                if (fl) col = 15 - col;
                v = bmp(row, col);
                if (v != 0) begin
                    cnt++;
                    if (cnt == 1) begin
                        e.hit = 1'b1;
                        e.id  = 3'(i);
                        case (v)
                            1: begin e.r = 8'hFF; e.g = 8'h00; e.b = 8'h00; end
                            2: begin e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF; end
                            default: begin e.r = 8'h21; e.g = 8'h21; e.b = 8'hFF; end
                        endcase
                    end
                end
            end
        end
        e.de    = de;
        e.multi = (cnt >= 2);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic rand_px(output int px, output int py);
        int sel, j;
        sel = $urandom_range(0, 4);
        j   = $urandom_range(0, 3);
        if (sel == 0) begin
            px = $urandom_range(0, 1300);
            py = $urandom_range(0, 730);
        end else if (sel == 1) begin
            px = tri_pos(nmov, 16) + $urandom_range(0, 67) - 2;
            py = tri_pos(nmov, YM) + $urandom_range(0, 67) - 2;
        end else begin
            px = tri_pos(j * 256 + nmov, 1216) + $urandom_range(0, 67) - 2;
            py = tri_pos(j * 96 + nmov, YM) + $urandom_range(0, 67) - 2;
        end
        if (px < 0) px = 0;
        if (py < 0) py = 0;
    endtask

    // One pixel clock: check the result from two steps back, drive, advance the model.
    task automatic step(input int px, input int py, input bit de, input bit vs, input bit men);
        exp_t e;
        bit   fs;
        bit   cn [3];
        for (int k = 0; k < 3; k++) chk($sformatf("d%0d_collision", k), 32'(coll[k]), 32'(mcoll[k]));
        if (qe.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
                e = qe.pop_front();
                chk($sformatf("d%0d_red", k),   32'(red[k]),   32'(e.r));
                chk($sformatf("d%0d_green", k), 32'(green[k]), 32'(e.g));
                chk($sformatf("d%0d_blue", k),  32'(blue[k]),  32'(e.b));
                chk($sformatf("d%0d_hit", k),   32'(hit[k]),   32'(e.hit));
                chk($sformatf("d%0d_id", k),    32'(sid[k]),   32'(e.id));
                chk($sformatf("d%0d_de", k),    32'(ode[k]),   32'(e.de));
            end
        end
        i_x = 16'(px); i_y = 16'(py); i_de = de; i_v_sync = vs; i_move_en = men;
        fs = armed && vs && !vs_prev;
        for (int k = 0; k < 3; k++) begin
            e = model_px(k, px, py, de);
            qe.push_back(e);
            cn[k] = prev_multi[k] | (mcoll[k] & ~fs);
            prev_multi[k] = e.multi;
        end
        if (fs && men) nmov++;
        vs_prev = vs;
        armed   = 1'b1;
        $display("step x=%0d y=%0d de=%0d vs=%0d men=%0d moves=%0d", px, py, de, vs, men, nmov);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) mcoll[k] = cn[k];
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst%0d_d%0d_red", pass, k),   32'(red[k]),   32'd0);
                chk($sformatf("rst%0d_d%0d_green", pass, k), 32'(green[k]), 32'd0);
                chk($sformatf("rst%0d_d%0d_blue", pass, k),  32'(blue[k]),  32'd0);
                chk($sformatf("rst%0d_d%0d_hit", pass, k),   32'(hit[k]),   32'd0);
                chk($sformatf("rst%0d_d%0d_id", pass, k),    32'(sid[k]),   32'd0);
                chk($sformatf("rst%0d_d%0d_de", pass, k),    32'(ode[k]),   32'd0);
                chk($sformatf("rst%0d_d%0d_coll", pass, k),  32'(coll[k]),  32'd0);
            end
            if (pass == 0) begin
                i_de = 1'b0; i_v_sync = 1'b0; i_move_en = 1'b0;
                @(posedge clk); #1;
            end
        end
        rst = 1'b0;
        qe.delete();
        nmov    = 0;
        vs_prev = 1'b0;
        armed   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mcoll[k]      = 1'b0;
            prev_multi[k] = 1'b0;
        end
        $display("reset applied and released");
    endtask

    initial begin
        int px, py, sx2, sy2;
        rst = 1'b1; i_x = '0; i_y = '0; i_de = 1'b0; i_v_sync = 1'b0; i_move_en = 1'b0;
        do_reset();

        // Frame 0 directed pixels, including the overlap point of the two-sprite instance.
        step(0, 0, 1, 0, 1);
        step(24, 4, 1, 0, 1);
        step(20, 12, 1, 0, 1);
        step(40, 36, 1, 0, 1);
        step(100, 100, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Frames with motion; probes track the narrow-screen sprite through its bounce.
        for (int f = 0; f < 40; f++) begin
            sx2 = tri_pos(nmov, 16); sy2 = tri_pos(nmov, YM);
            step(sx2 + 24, sy2 + 4, 1, 1, 1);
            sx2 = tri_pos(nmov, 16); sy2 = tri_pos(nmov, YM);
            step(sx2 + 36, sy2 + 4, 1, 0, 1);
            step(40, 36 + nmov, 1, 0, 1);
            rand_px(px, py);
            step(px, py, 1, 0, 1);
        end

        // Frozen motion across several v_sync edges, then a long high v_sync level.
        for (int f = 0; f < 5; f++) begin
            rand_px(px, py); step(px, py, 1, 1, 0);
            rand_px(px, py); step(px, py, 1, 0, 0);
        end
        for (int c = 0; c < 100; c++) begin
            rand_px(px, py); step(px, py, 1, 1, 1);
        end
        rand_px(px, py); step(px, py, 1, 0, 1);

        // Reset in the middle of active video, then the frame-0 pixels again.
        for (int c = 0; c < 4; c++) begin
            rand_px(px, py); step(px, py, 1, c[0], 1);
        end
        do_reset();
        step(24, 4, 1, 1, 1);
        step(20, 12, 1, 0, 1);
        step(40, 36, 1, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        for (int c = 0; c < 400; c++) begin
            rand_px(px, py);
            step(px, py, ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 4) != 0));
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
